// File: rtl/brq_pkg.sv
// -----------------------------------------------------------------------------
// brq_pkg: shared types for the core. This slice holds the floating-point CSR
// additions.
//   fp_fs_e      - mstatus.FS encoding (Off/Initial/Clean/Dirty)
//   fp_rm_e      - rounding-mode encodings from the rm field and frm
//   fflags_t     - accrued exception flags {nv,dz,of,uf,nx}
//   csr_op_e     - CSR operation encoding driven by the decoder
//   csr_num_e    - CSR addresses owned by the FP CSR responder
//   FCSR_FRM_LSB - bit position of frm inside fcsr
//   csr_apply_op - applies READ/WRITE/SET/CLEAR to an 8-bit field image
// -----------------------------------------------------------------------------
package brq_pkg;

    typedef enum logic [1:0] {
        FS_OFF     = 2'b00,
        FS_INITIAL = 2'b01,
        FS_CLEAN   = 2'b10,
        FS_DIRTY   = 2'b11
    } fp_fs_e;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4,
        RM_DYN = 3'd7
    } fp_rm_e;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    typedef enum logic [1:0] {
        CSR_OP_READ  = 2'b00,
        CSR_OP_WRITE = 2'b01,
        CSR_OP_SET   = 2'b10,
        CSR_OP_CLEAR = 2'b11
    } csr_op_e;

    typedef enum logic [11:0] {
        CSR_FFLAGS = 12'h001,
        CSR_FRM    = 12'h002,
        CSR_FCSR   = 12'h003
    } csr_num_e;

    localparam int unsigned FCSR_FRM_LSB = 5;

    // Only the low byte matters: fcsr is 8 bits wide and the other two CSRs
    // are narrower, so upper operand bits are discarded here.
    function automatic logic [7:0] csr_apply_op(input csr_op_e op,
                                                input logic [7:0] old_val,
                                                input logic [7:0] wdata);
        logic [7:0] res;
        case (op)
            CSR_OP_WRITE: res = wdata;
            CSR_OP_SET:   res = old_val | wdata;
            CSR_OP_CLEAR: res = old_val & ~wdata;
            default:      res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/brq_fp_csr_chk.sv
// -----------------------------------------------------------------------------
// brq_fp_csr_chk: protocol checks on the FPU issue/done handshake.
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   issue_i       - FP op issued
//   done_i        - FP op retired
//   full_i        - in-flight counter is full
//   empty_i       - in-flight counter is empty
// -----------------------------------------------------------------------------
module brq_fp_csr_chk (
    input logic clk_i,
    input logic rst_ni,
    input logic issue_i,
    input logic done_i,
    input logic full_i,
    input logic empty_i
);

    // The decoder must respect fpu_full_o; a simultaneous retire frees a slot.
    a_no_issue_when_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(issue_i && !done_i && full_i));

    // A retire with nothing in flight means the FPU and decoder disagree.
    a_no_done_when_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(done_i && empty_i));

endmodule

// File: rtl/brq_fp_inflight_cnt.sv
// -----------------------------------------------------------------------------
// brq_fp_inflight_cnt: saturating up/down counter of FPU ops issued but not yet
// retired.
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   issue_i       - +1 (held at MaxOutstanding)
//   done_i        - -1 (held at zero); issue and done together hold the count
//   cnt_o         - current count
//   full_o        - count equals MaxOutstanding
//   empty_o       - count is zero
// -----------------------------------------------------------------------------
module brq_fp_inflight_cnt #(
    parameter  int unsigned MaxOutstanding = 4,
    localparam int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            issue_i,
    input  logic            done_i,
    output logic [CntW-1:0] cnt_o,
    output logic            full_o,
    output logic            empty_o
);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;
    logic            full_s;
    logic            empty_s;

    assign full_s  = (cnt_q == CntW'(MaxOutstanding));
    assign empty_s = (cnt_q == {CntW{1'b0}});

    // Next count: saturate at both ends so protocol slips cannot wrap.
    always_comb begin
        cnt_d = cnt_q;
        case ({issue_i, done_i})
            2'b10: begin
                if (!full_s) begin
                    cnt_d = cnt_q + CntW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            2'b01: begin
                if (!empty_s) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: cnt_d = cnt_q;
        endcase
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= {CntW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign full_o  = full_s;
    assign empty_o = empty_s;

endmodule

// File: rtl/brq_fp_csr.sv
// -----------------------------------------------------------------------------
// brq_fp_csr: floating-point CSR responder (fflags 0x001, frm 0x002, fcsr
// 0x003). Accrues FPU exception flags, resolves dynamic rounding, tracks
// in-flight FPU ops and owns mstatus.FS.
// Build option: BRQ_FP_FS_TRACK_EN - when defined, FS is a real state machine;
// when undefined, FS reads as Dirty, FP is never off and fs_wr_* are ignored.
// Ports:
//   clk_i, rst_ni                  - clock, asynchronous active-low reset
//   csr_access_i/addr/op/wdata     - CSR instruction in EX
//   csr_hit_o, csr_rdata_o         - address decode and combinational read
//   csr_illegal_o, csr_stall_o     - FS-off trap and hold-in-EX request
//   fpu_issue_i, fpu_done_i        - FPU handshake; fpu_fflags_i valid on done
//   fpu_full_o                     - no more FP ops may be issued
//   fp_rf_we_i                     - FP register file write (dirties FS)
//   instr_rm_i, rm_o, rm_illegal_o - rounding-mode resolution
//   fs_wr_en_i, fs_wdata_i         - mstatus.FS write from the main CSR file
//   fs_o, fp_off_o, sd_o           - FS state and derived status
// -----------------------------------------------------------------------------
module brq_fp_csr
    import brq_pkg::*;
#(
    parameter  int unsigned MaxOutstanding = 4,
    localparam int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        csr_access_i,
    input  logic [11:0] csr_addr_i,
    input  logic [1:0]  csr_op_i,
    input  logic [31:0] csr_wdata_i,
    output logic        csr_hit_o,
    output logic [31:0] csr_rdata_o,
    output logic        csr_illegal_o,
    output logic        csr_stall_o,
    input  logic        fpu_issue_i,
    input  logic        fpu_done_i,
    input  logic [4:0]  fpu_fflags_i,
    output logic        fpu_full_o,
    input  logic        fp_rf_we_i,
    input  logic [2:0]  instr_rm_i,
    output logic [2:0]  rm_o,
    output logic        rm_illegal_o,
    input  logic        fs_wr_en_i,
    input  logic [1:0]  fs_wdata_i,
    output logic [1:0]  fs_o,
    output logic        fp_off_o,
    output logic        sd_o
);

    fflags_t         fflags_q;
    fflags_t         fflags_d;
    logic [2:0]      frm_q;
    logic [2:0]      frm_d;
    logic [CntW-1:0] cnt_s;
    logic            cnt_full_s;
    logic            cnt_empty_s;
    logic            hit_s;
    logic            flag_addr_s;
    logic [31:0]     rdata_s;
    logic [7:0]      new_val_s;
    logic            stall_s;
    logic            illegal_s;
    logic            commit_s;
    logic            wr_dirty_s;
    fp_fs_e          fs_s;
    logic            fp_off_s;
    logic [2:0]      rm_s;

    brq_fp_inflight_cnt #(
        .MaxOutstanding(MaxOutstanding)
    ) u_inflight_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .issue_i(fpu_issue_i),
        .done_i (fpu_done_i),
        .cnt_o  (cnt_s),
        .full_o (cnt_full_s),
        .empty_o(cnt_empty_s)
    );

    brq_fp_csr_chk u_chk (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .issue_i(fpu_issue_i),
        .done_i (fpu_done_i),
        .full_i (cnt_full_s),
        .empty_i(cnt_s == {CntW{1'b0}})
    );

    // Address decode and combinational read mux.
    always_comb begin
        hit_s       = 1'b0;
        flag_addr_s = 1'b0;
        rdata_s     = 32'd0;
        case (csr_addr_i)
            CSR_FFLAGS: begin
                hit_s       = 1'b1;
                flag_addr_s = 1'b1;
                rdata_s     = {27'd0, fflags_q};
            end
            CSR_FRM: begin
                hit_s   = 1'b1;
                rdata_s = {29'd0, frm_q};
            end
            CSR_FCSR: begin
                hit_s       = 1'b1;
                flag_addr_s = 1'b1;
                rdata_s     = {24'd0, frm_q, fflags_q};
            end
            default: begin
                hit_s       = 1'b0;
                flag_addr_s = 1'b0;
                rdata_s     = 32'd0;
            end
        endcase
    end

    // Reading flags while FPU ops are in flight would return stale flags.
    assign stall_s    = csr_access_i && flag_addr_s && !cnt_empty_s;
    assign illegal_s  = csr_access_i && hit_s && fp_off_s;
    assign commit_s   = csr_access_i && hit_s && !illegal_s && !stall_s &&
                        (csr_op_i != CSR_OP_READ);
    // SET/CLEAR with a zero operand change nothing and must not dirty FS.
    assign wr_dirty_s = commit_s &&
                        ((csr_op_i == CSR_OP_WRITE) || (csr_wdata_i != 32'd0));
    assign new_val_s  = csr_apply_op(csr_op_e'(csr_op_i), rdata_s[7:0], csr_wdata_i[7:0]);

    // Next fflags/frm: committed CSR write per field, then OR in retired flags.
    always_comb begin
        fflags_d = fflags_q;
        frm_d    = frm_q;
        if (commit_s) begin
            case (csr_addr_i)
                CSR_FFLAGS: fflags_d = fflags_t'(new_val_s[4:0]);
                CSR_FRM:    frm_d    = new_val_s[2:0];
                CSR_FCSR: begin
                    fflags_d = fflags_t'(new_val_s[4:0]);
                    frm_d    = new_val_s[FCSR_FRM_LSB +: 3];
                end
                default: begin
                    fflags_d = fflags_q;
                    frm_d    = frm_q;
                end
            endcase
        end else begin
            fflags_d = fflags_q;
            frm_d    = frm_q;
        end
        if (fpu_done_i) begin
            fflags_d = fflags_t'(fflags_d | fpu_fflags_i);
        end else begin
            fflags_d = fflags_d;
        end
    end

    // fflags and frm storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fflags_q <= fflags_t'(5'd0);
            frm_q    <= 3'd0;
        end else begin
            fflags_q <= fflags_d;
            frm_q    <= frm_d;
        end
    end

`ifdef BRQ_FP_FS_TRACK_EN
    fp_fs_e fs_q;
    fp_fs_e fs_d;

    // FS next state: explicit mstatus write wins, then any FP state change.
    always_comb begin
        fs_d = fs_q;
        if (fs_wr_en_i) begin
            fs_d = fp_fs_e'(fs_wdata_i);
        end else if (fpu_done_i || fp_rf_we_i || wr_dirty_s) begin
            fs_d = FS_DIRTY;
        end else begin
            fs_d = fs_q;
        end
    end

    // FS register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fs_q <= FS_INITIAL;
        end else begin
            fs_q <= fs_d;
        end
    end

    assign fs_s     = fs_q;
    assign fp_off_s = (fs_q == FS_OFF);
`else
    logic unused_fs_s;

    assign fs_s        = FS_DIRTY;
    assign fp_off_s    = 1'b0;
    assign unused_fs_s = ^{fs_wr_en_i, fs_wdata_i, fp_rf_we_i, wr_dirty_s};
`endif

    assign rm_s         = (instr_rm_i == RM_DYN) ? frm_q : instr_rm_i;
    assign rm_o         = rm_s;
    assign rm_illegal_o = (rm_s == 3'd5) || (rm_s == 3'd6) || (rm_s == 3'd7);

    assign csr_hit_o     = hit_s;
    assign csr_rdata_o   = rdata_s;
    assign csr_illegal_o = illegal_s;
    assign csr_stall_o   = stall_s;
    assign fpu_full_o    = cnt_full_s;
    assign fs_o          = fs_s;
    assign fp_off_o      = fp_off_s;
    assign sd_o          = (fs_s == FS_DIRTY);

endmodule

// File: tb/tb_brq_fp_csr.sv
// -----------------------------------------------------------------------------
// tb_brq_fp_csr: directed scenarios followed by constrained-random traffic for
// brq_fp_csr, all outputs compared every cycle against an arithmetic reference
// model. Builds with or without BRQ_FP_FS_TRACK_EN.
// -----------------------------------------------------------------------------
module tb_brq_fp_csr;
    import brq_pkg::*;

    localparam int MAXO = 4;
`ifdef BRQ_FP_FS_TRACK_EN
    localparam bit FsTrack = 1'b1;
`else
    localparam bit FsTrack = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        csr_access;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic [31:0] csr_wdata;
    logic        csr_hit;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        csr_stall;
    logic        fpu_issue;
    logic        fpu_done;
    logic [4:0]  fpu_fflags;
    logic        fpu_full;
    logic        fp_rf_we;
    logic [2:0]  instr_rm;
    logic [2:0]  rm;
    logic        rm_illegal;
    logic        fs_wr_en;
    logic [1:0]  fs_wdata;
    logic [1:0]  fs;
    logic        fp_off;
    logic        sd;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_fflags, m_frm, m_cnt, m_fs;

    always #5 clk = ~clk;

    brq_fp_csr #(.MaxOutstanding(MAXO)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .csr_access_i (csr_access),
        .csr_addr_i   (csr_addr),
        .csr_op_i     (csr_op),
        .csr_wdata_i  (csr_wdata),
        .csr_hit_o    (csr_hit),
        .csr_rdata_o  (csr_rdata),
        .csr_illegal_o(csr_illegal),
        .csr_stall_o  (csr_stall),
        .fpu_issue_i  (fpu_issue),
        .fpu_done_i   (fpu_done),
        .fpu_fflags_i (fpu_fflags),
        .fpu_full_o   (fpu_full),
        .fp_rf_we_i   (fp_rf_we),
        .instr_rm_i   (instr_rm),
        .rm_o         (rm),
        .rm_illegal_o (rm_illegal),
        .fs_wr_en_i   (fs_wr_en),
        .fs_wdata_i   (fs_wdata),
        .fs_o         (fs),
        .fp_off_o     (fp_off),
        .sd_o         (sd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_fflags = 0;
        m_frm    = 0;
        m_cnt    = 0;
        m_fs     = 1;
    endtask

    function automatic int e_hit();
        return (csr_addr >= 12'd1 && csr_addr <= 12'd3) ? 1 : 0;
    endfunction

    function automatic int e_rdata();
        if (csr_addr == 12'd1) return m_fflags;
        if (csr_addr == 12'd2) return m_frm;
        if (csr_addr == 12'd3) return m_frm * 32 + m_fflags;
        return 0;
    endfunction

    function automatic int e_fs();
        return FsTrack ? m_fs : 3;
    endfunction

    function automatic int e_illegal();
        return (csr_access && e_hit() == 1 && e_fs() == 0) ? 1 : 0;
    endfunction

    function automatic int e_stall();
        return (csr_access && (csr_addr == 12'd1 || csr_addr == 12'd3) && m_cnt != 0) ? 1 : 0;
    endfunction

    function automatic int e_rm();
        return (instr_rm == 3'd7) ? m_frm : int'(instr_rm);
    endfunction

    task automatic check_outputs();
        chk("hit",        {31'd0, csr_hit},     e_hit());
        chk("rdata",      csr_rdata,            e_rdata());
        chk("illegal",    {31'd0, csr_illegal}, e_illegal());
        chk("stall",      {31'd0, csr_stall},   e_stall());
        chk("full",       {31'd0, fpu_full},    (m_cnt == MAXO) ? 1 : 0);
        chk("rm",         {29'd0, rm},          e_rm());
        chk("rm_illegal", {31'd0, rm_illegal},  (e_rm() >= 5) ? 1 : 0);
        chk("fs",         {30'd0, fs},          e_fs());
        chk("fp_off",     {31'd0, fp_off},      (e_fs() == 0) ? 1 : 0);
        chk("sd",         {31'd0, sd},          (e_fs() == 3) ? 1 : 0);
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic update_model();
        int  old_v, wd, nv;
        bit  commit;
        commit = csr_access && e_hit() == 1 && e_illegal() == 0 && e_stall() == 0
                 && csr_op != 2'd0;
        old_v  = e_rdata();
        wd     = int'(csr_wdata[7:0]);
        nv     = (csr_op == 2'd1) ? wd : (csr_op == 2'd2) ? (old_v | wd) : (old_v & ~wd);
        if (commit) begin
            if (csr_addr == 12'd1) m_fflags = nv % 32;
            if (csr_addr == 12'd2) m_frm = nv % 8;
            if (csr_addr == 12'd3) begin
                m_fflags = nv % 32;
                m_frm    = (nv / 32) % 8;
            end
        end
        if (fpu_done) m_fflags = m_fflags | int'(fpu_fflags);
        if (fpu_issue && !fpu_done && m_cnt < MAXO) m_cnt = m_cnt + 1;
        if (fpu_done && !fpu_issue && m_cnt > 0) m_cnt = m_cnt - 1;
        if (fs_wr_en) m_fs = int'(fs_wdata);
        else if (fpu_done || fp_rf_we ||
                 (commit && (csr_op == 2'd1 || csr_wdata != 32'd0))) m_fs = 3;
    endtask

    task automatic idle();
        csr_access = 1'b0; csr_addr = 12'd0; csr_op = 2'd0; csr_wdata = 32'd0;
        fpu_issue = 1'b0; fpu_done = 1'b0; fpu_fflags = 5'd0; fp_rf_we = 1'b0;
        instr_rm = 3'd0; fs_wr_en = 1'b0; fs_wdata = 2'd0;
    endtask

    task automatic csr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd);
        csr_access = 1'b1; csr_addr = a; csr_op = op; csr_wdata = wd;
    endtask

    // Called just after a falling edge with inputs driven.
    task automatic cycle();
        #1;
        check_outputs();
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state and fcsr write
        csr(12'h003, 2'd0, 32'd0);
        #1 chk("reset_fcsr", csr_rdata, 32'd0);
        cycle();
        idle(); csr(12'h003, 2'd1, 32'hFF); cycle();
        idle(); csr(12'h003, 2'd0, 32'd0);
        #1 chk("fcsr_ff", csr_rdata, 32'hFF);
        chk("sd_after_wr", {31'd0, sd}, 32'd1);
        cycle();
        idle(); csr(12'h003, 2'd1, 32'd0); cycle();

        // Flag reads stall until both ops retire
        idle(); fpu_issue = 1'b1; cycle(); cycle();
        idle(); csr(12'h001, 2'd0, 32'd0); fpu_done = 1'b1; fpu_fflags = 5'b00001;
        #1 chk("stall_cnt2", {31'd0, csr_stall}, 32'd1);
        cycle();
        fpu_fflags = 5'b10000; cycle();
        idle(); csr(12'h001, 2'd0, 32'd0);
        #1 chk("stall_drop", {31'd0, csr_stall}, 32'd0);
        chk("fflags_11", csr_rdata, 32'h11);
        cycle();

        // frm writes never stall; dynamic rounding
        idle(); fpu_issue = 1'b1; cycle();
        idle(); csr(12'h002, 2'd1, 32'd5);
        #1 chk("frm_nostall", {31'd0, csr_stall}, 32'd0);
        cycle();
        idle(); instr_rm = 3'd7;
        #1 chk("rm_dyn", {29'd0, rm}, 32'd5);
        chk("rm_dyn_ill", {31'd0, rm_illegal}, 32'd1);
        cycle();
        instr_rm = 3'd1;
        #1 chk("rm_static", {29'd0, rm}, 32'd1);
        chk("rm_static_ill", {31'd0, rm_illegal}, 32'd0);
        cycle();
        idle(); fpu_done = 1'b1; cycle();

        // FS off / priority of mstatus write over done
        idle(); fs_wr_en = 1'b1; fs_wdata = 2'b00; cycle();
        idle(); csr(12'h002, 2'd1, 32'd3); cycle();
        idle(); csr(12'h002, 2'd0, 32'd0); cycle();
        idle(); fpu_issue = 1'b1; cycle();
        idle(); fs_wr_en = 1'b1; fs_wdata = 2'b10; fpu_done = 1'b1; cycle();

        // Saturation at MaxOutstanding
        idle(); fpu_issue = 1'b1;
        for (int i = 0; i < MAXO; i++) cycle();
        #1 chk("full_at_max", {31'd0, fpu_full}, 32'd1);
        fpu_done = 1'b1; cycle();
        idle();
        #1 chk("full_hold", {31'd0, fpu_full}, 32'd1);
        fpu_done = 1'b1;
        for (int i = 0; i < MAXO; i++) cycle();

        // Zero-operand CLEAR keeps FS; SET dirties it
        idle(); fs_wr_en = 1'b1; fs_wdata = 2'b10; cycle();
        idle(); csr(12'h001, 2'd3, 32'd0); cycle();
        idle(); csr(12'h001, 2'd2, 32'd4); cycle();
        idle(); csr(12'h001, 2'd0, 32'd0);
        #1 chk("fflags_set", csr_rdata, 32'h15);
        cycle();

        // Constrained-random traffic
        for (int n = 0; n < 400; n++) begin
            idle();
            csr_access = ($urandom_range(0, 2) != 0);
            csr_addr   = 12'($urandom_range(0, 4));
            if ($urandom_range(0, 15) == 0) csr_addr = 12'($urandom);
            csr_op     = 2'($urandom_range(0, 3));
            csr_wdata  = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
            fpu_issue  = ($urandom_range(0, 2) == 0) && (m_cnt < MAXO);
            fpu_done   = ($urandom_range(0, 2) == 0) && (m_cnt > 0);
            fpu_fflags = 5'($urandom);
            fp_rf_we   = ($urandom_range(0, 7) == 0);
            instr_rm   = 3'($urandom);
            fs_wr_en   = ($urandom_range(0, 9) == 0);
            fs_wdata   = 2'($urandom);
            if (fpu_issue && m_cnt == MAXO - 1 && $urandom_range(0, 1) == 0) fpu_done = (m_cnt > 0);
            cycle();
        end

        // Asynchronous reset with ops in flight
        idle(); fpu_issue = (m_cnt < MAXO); cycle();
        idle(); csr(12'h001, 2'd0, 32'd0);
        rst_n = 1'b0;
        model_reset();
        #1 chk("rst_mid_stall", {31'd0, csr_stall}, 32'd0);
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
